// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter.
// State encoding, requester indices and the latched transaction bundle.
package mem_port_arbiter_pkg;

   localparam int unsigned DW = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_DM = 1'b1;

   typedef struct packed {
      logic [DW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          we;
   } mem_txn_t;

   // Fetches never write, so their bundle carries zero data and we = 0.
   function automatic mem_txn_t fetch_txn(input logic [DW-1:0] a);
      mem_txn_t t;
      t.addr  = a;
      t.wdata = '0;
      t.we    = 1'b0;
      return t;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie the requester not served last wins.
module rr_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       vld,
   output logic       idx
);

   // Pick the winner from the eligible request vector.
   always_comb begin
      vld = |req;
      idx = REQ_IF;
      unique case (1'b1)
         (req == 2'b11): idx = ~last;
         (req == 2'b10): idx = REQ_DM;
         default:        idx = REQ_IF;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port.
// Round-robin on ties, wait-cycle timeout aborts a stalled access.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [DW-1:0] if_addr,
   input  logic          dm_req,
   input  logic [DW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   input  logic          dm_we,
   output logic          mem_req,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          sel,
   output logic          if_done,
   output logic          dm_done,
   output logic [DW-1:0] rdata,
   output logic          err
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   arb_state_t state;
   arb_state_t state_n;
   logic [7:0] cnt;
   logic       last;
   logic [1:0] elig;
   logic       pick_vld;
   logic       pick_idx;
   logic       grant;
   logic       complete;
   logic       abort;
   mem_txn_t   win_txn;

   // A requester in its done cycle still holds a stale req; mask it.
   assign elig = {dm_req & ~dm_done, if_req & ~if_done};

   rr_pick2 u_pick (
      .req  (elig),
      .last (last),
      .vld  (pick_vld),
      .idx  (pick_idx)
   );

   // Bundle the winning requester's address/data for latching.
   always_comb begin
      win_txn = fetch_txn(if_addr);
      if (pick_idx == REQ_DM) begin
         win_txn.addr  = dm_addr;
         win_txn.wdata = dm_wdata;
         win_txn.we    = dm_we;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next state and transaction events; ack beats the timeout.
   always_comb begin
      state_n  = state;
      grant    = 1'b0;
      complete = 1'b0;
      abort    = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_vld) begin
               grant   = 1'b1;
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack) begin
               complete = 1'b1;
               state_n  = IDLE;
            end else if (cnt == TO_LAST) begin
               abort   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Wait counter: cleared on grant, counts unacked BUSY cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt <= '0;
      else if (grant)              cnt <= '0;
      else if (state == BUSY &&
               !complete && !abort) cnt <= cnt + 8'd1;
   end

   // Memory-side request, latched bundle and owner select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         sel       <= REQ_IF;
      end else if (grant) begin
         mem_req   <= 1'b1;
         mem_addr  <= win_txn.addr;
         mem_wdata <= win_txn.wdata;
         mem_we    <= win_txn.we;
         sel       <= pick_idx;
      end else if (complete || abort) begin
         mem_req   <= 1'b0;
      end
   end

   // Completion pulses, error flag, read data and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_done <= 1'b0;
         dm_done <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         last    <= REQ_DM;
      end else begin
         if_done <= 1'b0;
         dm_done <= 1'b0;
         err     <= 1'b0;
         if (complete || abort) begin
            if (sel == REQ_DM) dm_done <= 1'b1;
            else               if_done <= 1'b1;
            err  <= abort;
            last <= sel;
         end
         if (complete && !mem_we) rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Each step drives inputs 1 time unit after the rising edge and checks.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        dm_req;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_we;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        sel;
   logic        if_done;
   logic        dm_done;
   logic [31:0] rdata;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   mem_port_arbiter #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .dm_req    (dm_req),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_we     (dm_we),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .sel       (sel),
      .if_done   (if_done),
      .dm_done   (dm_done),
      .rdata     (rdata),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      if_req    = 1'b0;
      if_addr   = '0;
      dm_req    = 1'b0;
      dm_addr   = '0;
      dm_wdata  = '0;
      dm_we     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;

      #12;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_flags", {29'd0, if_done, dm_done, err}, 32'd0);
      rst_n = 1'b1;
      step();

      // Fetch only, ack 3 cycles after mem_req rises.
      if_req  = 1'b1;
      if_addr = 32'h0040_0000;
      step();
      chk("f_mem_req", 32'(mem_req), 32'd1);
      chk("f_sel", 32'(sel), 32'd0);
      chk("f_addr", mem_addr, 32'h0040_0000);
      chk("f_we_wd", {mem_wdata[30:0], mem_we}, 32'd0);
      step();
      step();
      chk("f_sel_busy", 32'(sel), 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'h8C02_0004;
      step();
      mem_ack = 1'b0;
      chk("f_req_fall", 32'(mem_req), 32'd0);
      chk("f_done", 32'(if_done), 32'd1);
      chk("f_rdata", rdata, 32'h8C02_0004);
      chk("f_err", 32'(err), 32'd0);
      step();
      chk("f_done_pulse", 32'(if_done), 32'd0);
      chk("f_no_regrant", 32'(mem_req), 32'd0);
      step();
      chk("f_regrant", 32'(mem_req), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_1111;
      if_req    = 1'b0;
      step();
      mem_ack = 1'b0;
      chk("f2_done", 32'(if_done), 32'd1);

      // Ack while idle is ignored.
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 1'b0;
      chk("idle_ack_rdata", rdata, 32'h1111_1111);
      chk("idle_ack_done", {30'd0, if_done, dm_done}, 32'd0);
      chk("idle_ack_req", 32'(mem_req), 32'd0);

      // Store.
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h1001_0000;
      dm_wdata = 32'hDEAD_BEEF;
      step();
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_addr", mem_addr, 32'h1001_0000);
      chk("st_sel", 32'(sel), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_5678;
      step();
      mem_ack = 1'b0;
      dm_req  = 1'b0;
      dm_we   = 1'b0;
      chk("st_done", 32'(dm_done), 32'd1);
      chk("st_rdata", rdata, 32'h1111_1111);
      chk("st_req_fall", 32'(mem_req), 32'd0);

      // Timeout with no ack.
      if_req  = 1'b1;
      if_addr = 32'h0040_0010;
      step();
      chk("to_req_on", 32'(mem_req), 32'd1);
      repeat (15) step();
      chk("to_last_busy", 32'(mem_req), 32'd1);
      chk("to_no_done", 32'(if_done), 32'd0);
      step();
      if_req = 1'b0;
      chk("to_req_fall", 32'(mem_req), 32'd0);
      chk("to_done", 32'(if_done), 32'd1);
      chk("to_err", 32'(err), 32'd1);
      chk("to_rdata", rdata, 32'h1111_1111);
      step();
      chk("to_err_pulse", 32'(err), 32'd0);

      // Ack on the threshold cycle completes normally.
      if_req = 1'b1;
      step();
      repeat (15) step();
      mem_ack   = 1'b1;
      mem_rdata = 32'hA5A5_5A5A;
      step();
      mem_ack = 1'b0;
      if_req  = 1'b0;
      chk("th_done", 32'(if_done), 32'd1);
      chk("th_err", 32'(err), 32'd0);
      chk("th_rdata", rdata, 32'hA5A5_5A5A);
      step();

      // Async reset mid-transaction.
      dm_req  = 1'b1;
      dm_addr = 32'h1001_0040;
      step();
      chk("rb_sel", 32'(sel), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ra_req", 32'(mem_req), 32'd0);
      chk("ra_addr", mem_addr, 32'd0);
      chk("ra_sel", 32'(sel), 32'd0);
      chk("ra_rdata", rdata, 32'd0);
      chk("ra_flags", {29'd0, if_done, dm_done, err}, 32'd0);
      #2;
      if_req  = 1'b1;
      if_addr = 32'h0040_0020;
      rst_n   = 1'b1;
      step();
      chk("rr_tie_sel", 32'(sel), 32'd0);
      chk("rr_tie_req", 32'(mem_req), 32'd1);
      chk("rr_no_done", {30'd0, if_done, dm_done}, 32'd0);

      // Tie alternation: data wins in the fetch done cycle.
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("alt_if_done", 32'(if_done), 32'd1);
      step();
      chk("alt_dm_sel", 32'(sel), 32'd1);
      chk("alt_dm_req", 32'(mem_req), 32'd1);
      chk("alt_dm_addr", mem_addr, 32'h1001_0040);

      // Owner drops req mid-transaction, other requester waits.
      dm_req = 1'b0;
      step();
      chk("drop_req", 32'(mem_req), 32'd1);
      chk("drop_sel", 32'(sel), 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("drop_done", 32'(dm_done), 32'd1);
      step();
      chk("next_sel", 32'(sel), 32'd0);
      chk("next_req", 32'(mem_req), 32'd1);
      chk("next_addr", mem_addr, 32'h0040_0020);
      if_req  = 1'b0;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("next_done", 32'(if_done), 32'd1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
